// File: rtl/md_pkg.sv
// Shared types for the multiply/divide unit: operation codes and FSM states.
// Pure declarations, no logic or latency of its own.
// No flow control; consumers stall on md_unit busy.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_NOP7  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Countdown width; holds up to 15 busy cycles.
    localparam int CNT_W = 4;

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_unit.sv
// MIPS E-stage mult/div unit holding HI/LO; result computed at issue, retired after a fixed count.
// Latency: MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu) busy cycles; mthi/mtlo write at issue edge.
// Backpressure: busy high while an op is in flight; start during busy is ignored.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

    md_op_e      op;
    logic        mul_signed, div_signed, b_zero;
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;
    logic        q_neg, r_neg;

    assign op = md_op_e'(md_op);

    // Product: the low 64 bits of a 64x64 multiply of sign- or zero-extended operands.
    always_comb begin
        mul_signed = (op == MD_MULT);
        a_ext      = mul_signed ? {{32{A[31]}}, A} : {32'd0, A};
        b_ext      = mul_signed ? {{32{B[31]}}, B} : {32'd0, B};
        prod       = a_ext * b_ext;
    end

    // Quotient/remainder via unsigned magnitudes; quotient truncates toward zero,
    // remainder takes the dividend's sign. 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        div_signed = (op == MD_DIV);
        b_zero     = (B == 32'd0);
        a_mag      = div_signed ? abs32(A) : A;
        b_mag      = div_signed ? abs32(B) : B;
        // Divisor forced to 1 when zero so the datapath never divides by zero;
        // the result is discarded in that case anyway.
        b_div      = b_zero ? 32'd1 : b_mag;
        q_mag      = a_mag / b_div;
        r_mag      = a_mag % b_div;
        q_neg      = div_signed & (A[31] ^ B[31]);
        r_neg      = div_signed & A[31];
        quot       = q_neg ? (~q_mag + 32'd1) : q_mag;
        rem        = r_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // Next-state: issue in IDLE, countdown and retire in RUN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            hi_tmp_d = prod[63:32];
                            lo_tmp_d = prod[31:0];
                            cnt_d    = MULT_LOAD;
                            state_d  = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            // Divide by zero leaves the unit untouched.
                            if (!b_zero) begin
                                hi_tmp_d = rem;
                                lo_tmp_d = quot;
                                cnt_d    = DIV_LOAD;
                                state_d  = ST_RUN;
                            end
                        end
                        MD_MTHI: hi_d = A;
                        MD_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // start is ignored here; the pending result is not disturbed.
                if (cnt_q == CNT_ONE) begin
                    hi_d    = hi_tmp_q;
                    lo_d    = lo_tmp_q;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset clears everything including the pending result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table plus reset and overlap sequences.
// Expected HI/LO/busy-cycle counts queued at issue, popped when busy drops.
// Every wait on busy is bounded.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    vec_t vecs [14];
    exp_t sb [$];
    exp_t e;

    int n_cmp;
    int n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Issue one op (call #1 after an edge); optionally inject a mult at busy cycle inj.
    // Returns the number of cycles busy stayed high.
    task automatic issue_measure(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int inj, output int cyc);
        int n;
        start = 1'b1; md_op = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0; A = 32'hDEAD_BEEF; B = 32'h0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == inj) begin
                start = 1'b1; md_op = 3'd1; A = 32'd3; B = 32'd3;
            end
            @(posedge clk); #1;
            start = 1'b0; md_op = 3'd0;
        end
        cyc = n;
    endtask

    initial begin
        int cyc;
        n_cmp = 0;
        n_err = 0;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{3'd4, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 10};
        vecs[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[5]  = '{3'd3, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 0};
        vecs[6]  = '{3'd5, 32'h0000_1234, 32'h0000_0009, 32'h0000_1234, 32'h8000_0000, 0};
        vecs[7]  = '{3'd6, 32'h0000_CAFE, 32'h0000_0009, 32'h0000_1234, 32'h0000_CAFE, 0};
        vecs[8]  = '{3'd0, 32'h0000_FFFF, 32'h0000_0003, 32'h0000_1234, 32'h0000_CAFE, 0};
        vecs[9]  = '{3'd7, 32'h0000_FFFF, 32'h0000_0003, 32'h0000_1234, 32'h0000_CAFE, 0};
        vecs[10] = '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
        vecs[11] = '{3'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 10};
        vecs[12] = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[13] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};

        reset = 1'b0; start = 1'b0; md_op = 3'd0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Table-driven operations.
        for (int i = 0; i < 14; i++) begin
            sb.push_back('{vecs[i].hi, vecs[i].lo, vecs[i].cyc});
            issue_measure(vecs[i].op, vecs[i].a, vecs[i].b, 0, cyc);
            e = sb.pop_front();
            check($sformatf("v%0d_cycles", i), cyc, e.cyc);
            check($sformatf("v%0d_hi", i), HI, e.hi);
            check($sformatf("v%0d_lo", i), LO, e.lo);
        end

        // Asynchronous reset mid-cycle with non-zero HI/LO, no clock edge in between.
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_hi", HI, 32'd0);
        check("async_rst_lo", LO, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // mult issued in busy cycle 3 of a div must not disturb it: 100/7 = 14 rem 2.
        sb.push_back('{32'd2, 32'd14, 10});
        issue_measure(3'd3, 32'd100, 32'd7, 3, cyc);
        e = sb.pop_front();
        check("overlap_cycles", cyc, e.cyc);
        check("overlap_hi", HI, e.hi);
        check("overlap_lo", LO, e.lo);

        // Reset in busy cycle 3 of a div: nothing is written back afterwards.
        start = 1'b1; md_op = 3'd3; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        check("midrst_busy_before", {31'd0, busy}, 32'd1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2;
        reset = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst%0d", k), {busy, HI[30:0] | LO[30:0]} | {HI[31] | LO[31], 31'd0}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. It sits beside the ALU, takes forwarded rs/rt operands, and runs mult/multu/div/divu over a fixed number of cycles. It holds the architectural HI/LO registers. Its `busy` output feeds the hazard unit, which stalls any D-stage mult/div/mfhi/mflo/mthi/mtlo while `start` or `busy` is high.

## Interface
- `MULT_CYCLES`, default 5: busy duration of mult/multu, in cycles.
- `DIV_CYCLES`, default 10: busy duration of div/divu, in cycles.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `reset  in  1`: reset is asynchronous and active-low; all state clears immediately while low.
- `start  in  1`: E-stage instruction is an md instruction; qualifies `md_op`.
- `md_op  in  3`: operation code.
  - 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
  - 0 and 7 are no-op.
- `A  in  32`: forwarded rs value (RS_E after forwarding).
- `B  in  32`: forwarded rt value (RT_E after forwarding).
- `busy  out  1`: an operation is in flight.
- `HI  out  32`: HI register, read by mfhi.
- `LO  out  32`: LO register, read by mflo.

## Operation
- Reset values: `HI` 0, `LO` 0, `busy` 0, counter 0, pending result 0.
- **IDLE state** (`busy` = 0). On `start` at an edge:
  - mult/multu:
    - Product is computed combinationally: signed or unsigned 32×32→64.
    - Latch HI_tmp = product[63:32] and LO_tmp = product[31:0].
    - Load counter = MULT_CYCLES, go to RUN.
  - div/divu with B ≠ 0:
    - LO_tmp = quotient, truncated toward zero.
    - HI_tmp = remainder, carrying the sign of the dividend.
    - Signed overflow 0x80000000 / 0xFFFFFFFF gives LO_tmp = 0x80000000, HI_tmp = 0.
    - Load counter = DIV_CYCLES, go to RUN.
  - div/divu with B = 0: no state change, stay IDLE, HI/LO keep their values.
  - mthi/mtlo: write A into HI or LO at this edge; stay IDLE; `busy` never rises.
  - op 0 or 7: ignored.
- **RUN state** (`busy` = 1):
  - Counter decrements each edge.
  - At the edge where counter = 1: HI ← HI_tmp, LO ← LO_tmp, go to IDLE.
  - `start` in RUN is ignored. The hazard unit guarantees this never happens; the unit stays safe regardless.
- Widths: counter is 4 bits, sized for max(MULT_CYCLES, DIV_CYCLES) ≤ 15. Both parameters must be ≥ 1.

## Timing
- `start` sampled at edge t.
- mult/multu:
  - `busy` = 1 from t through t+MULT_CYCLES.
  - HI/LO updated at edge t+MULT_CYCLES.
  - `busy` = 0 in the same cycle the new HI/LO are visible.
- div/divu: the same, with DIV_CYCLES.
- mthi/mtlo: HI/LO updated at edge t; zero busy cycles.
- `HI`/`LO` are register outputs with no combinational path from A/B.
- Reset mid-operation: `busy`, counter, HI and LO clear asynchronously. No writeback occurs after reset releases.
- Reset release: the first edge with reset high may accept `start`.

## Structure
- md_op encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO) go in the shared define.v, next to the opcode/func defines.
- Decode of IR_E into start/md_op happens in the E-stage controller, not in this block.
- No sub-module is needed. Product and quotient/remainder are inline combinational logic; the FSM is the 1-bit busy flag plus the counter.

## Test plan
- Reset: assert reset low mid-cycle → HI = LO = 0 and busy = 0 immediately, with no clock edge required.
- Signed multiply: mult, A = 0xFFFFFFFF, B = 2 → busy high for 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
- Unsigned multiply: multu, same operands → HI = 0x00000001, LO = 0xFFFFFFFE after 5 busy cycles.
- Divide:
  - div, A = 0xFFFFFFF9 (−7), B = 2 → after 10 busy cycles, LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - divu, A = 7, B = 2 → LO = 3, HI = 1.
  - div, A = 0x80000000, B = 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Edge cases:
  - div with B = 0 → busy stays 0, HI/LO unchanged.
  - mthi A = 0x1234 → HI = 0x1234 after one edge, busy stays 0.
  - mult issued during a running div → ignored; the div result is written at its original completion edge.
- Reset mid-operation: start div, assert reset in busy cycle 3, release → busy = 0 and HI = LO = 0; no update appears 7 cycles later.
